// File: rtl/seven_seg_scan_driver_if.sv
// Control/display bundle for the multiplexed seven-segment scan driver.
// The master side supplies value/timing controls; the slave side drives the display pins.
interface seven_seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [3:0]            brightness;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output enable, load, value, dp_in, blank_lz, brightness,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz, brightness,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-slot PWM brightness, leading-zero
// blanking and a double-buffered value that only changes at frame boundaries.
module seven_seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SUB_DIV        = 3125,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    seven_seg_scan_driver_if.slave bus
);
    localparam int PRE_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SUB_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic              SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic              AN_INV   = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_INV}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_INV}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]    pre_r;
    logic [3:0]          sub_r;
    logic [DIG_W-1:0]    digit_r;
    logic [4*DIGITS-1:0] pend_val_r;
    logic [DIGITS-1:0]   pend_dp_r;
    logic [4*DIGITS-1:0] act_val_r;
    logic [DIGITS-1:0]   act_dp_r;
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic                frame_done_r;

    logic                pre_wrap_s;
    logic                slot_end_s;
    logic                frame_end_s;
    logic                lit_s;
    logic                zero_above_s;
    logic [3:0]          nib_s;
    logic                dp_sel_s;
    logic                blank_sel_s;
    logic [DIGITS-1:0]   an_on_s;
    logic [DIGITS-1:0]   an_nxt_s;
    logic [6:0]          seg_nxt_s;
    logic                dp_nxt_s;

    // Counter wrap detection for sub-step, slot and frame
    always_comb begin
        pre_wrap_s  = (pre_r == PRE_LAST);
        slot_end_s  = pre_wrap_s && (sub_r == 4'hF);
        frame_end_s = slot_end_s && (digit_r == DIG_LAST);
    end

    // Scan counters: pre-divider, brightness sub-step and digit index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_r   <= {PRE_W{1'b0}};
            sub_r   <= 4'h0;
            digit_r <= {DIG_W{1'b0}};
        end else if (!bus.enable) begin
            pre_r   <= {PRE_W{1'b0}};
            sub_r   <= 4'h0;
            digit_r <= {DIG_W{1'b0}};
        end else if (pre_wrap_s) begin
            pre_r <= {PRE_W{1'b0}};
            sub_r <= sub_r + 4'h1;
            if (slot_end_s) begin
                digit_r <= (digit_r == DIG_LAST) ? {DIG_W{1'b0}} : digit_r + DIG_W'(1);
            end else begin
                digit_r <= digit_r;
            end
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Pending/active double buffer; a load landing on the boundary bypasses pending
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_val_r <= {(4*DIGITS){1'b0}};
            pend_dp_r  <= {DIGITS{1'b0}};
            act_val_r  <= {(4*DIGITS){1'b0}};
            act_dp_r   <= {DIGITS{1'b0}};
        end else begin
            if (bus.load) begin
                pend_val_r <= bus.value;
                pend_dp_r  <= bus.dp_in;
            end
            if (bus.enable && frame_end_s) begin
                act_val_r <= bus.load ? bus.value : pend_val_r;
                act_dp_r  <= bus.load ? bus.dp_in : pend_dp_r;
            end
        end
    end

    // Digit select, leading-zero blanking and polarity of the next pin values
    always_comb begin
        zero_above_s = 1'b1;
        nib_s        = 4'h0;
        dp_sel_s     = 1'b0;
        blank_sel_s  = 1'b0;
        an_on_s      = {DIGITS{1'b0}};
        lit_s        = (sub_r < bus.brightness);
        // Walk from the leftmost digit so zero_above_s covers digits DIGITS-1..i
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above_s = zero_above_s && (act_val_r[i*4 +: 4] == 4'h0);
            nib_s        = (DIG_W'(i) == digit_r) ? act_val_r[i*4 +: 4] : nib_s;
            dp_sel_s     = (DIG_W'(i) == digit_r) ? act_dp_r[i] : dp_sel_s;
            blank_sel_s  = (DIG_W'(i) == digit_r) ? (bus.blank_lz && (i != 0) && zero_above_s)
                                                  : blank_sel_s;
            an_on_s[i]   = (DIG_W'(i) == digit_r) && lit_s;
        end
        an_nxt_s  = an_on_s ^ AN_OFF;
        seg_nxt_s = (lit_s && !blank_sel_s) ? (hex_to_seg(nib_s) ^ SEG_OFF) : SEG_OFF;
        dp_nxt_s  = lit_s ? (dp_sel_s ^ SEG_INV) : SEG_INV;
    end

    // Registered pin drive, one cycle behind the counter state that selects it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            dp_r         <= SEG_INV;
            frame_done_r <= 1'b0;
        end else if (!bus.enable) begin
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            dp_r         <= SEG_INV;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_nxt_s;
            seg_r        <= seg_nxt_s;
            dp_r         <= dp_nxt_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (DIGITS=4, SUB_DIV=2, active-low pins)
// against a time-arithmetic reference model.
module tb_seven_seg_scan_driver;
    localparam int DIGITS  = 4;
    localparam int SUB_DIV = 2;
    localparam int SLOT    = 16 * SUB_DIV;
    localparam int FRAME   = SLOT * DIGITS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan_driver #(
        .DIGITS(DIGITS), .SUB_DIV(SUB_DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: enabled-cycle count plus the two buffers
    int          m_cnt;
    logic [15:0] m_pend_val, m_act_val;
    logic [3:0]  m_pend_dp, m_act_dp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;

    wire [12:0] obs_v = {bus.an, bus.seg, bus.dp, bus.frame_done};
    wire [12:0] exp_v = {exp_an, exp_seg, exp_dp, exp_fd};

    // Observation tallies gathered between edges
    int         lit_cnt [4];
    logic [6:0] last_seg [4];
    logic       last_dp [4];
    int         dp_low_cnt;
    int         fd_cnt;

    always begin
        @(posedge clock);
        #2;
        if (reset) begin
            if (bus.frame_done) fd_cnt++;
            if (!bus.dp) dp_low_cnt++;
            for (int i = 0; i < DIGITS; i++) begin
                if (!bus.an[i]) begin
                    lit_cnt[i]++;
                    last_seg[i] = bus.seg;
                    last_dp[i]  = bus.dp;
                end
            end
        end
    end

    task automatic clear_tally();
        for (int i = 0; i < DIGITS; i++) begin
            lit_cnt[i]  = 0;
            last_seg[i] = 7'h55;
            last_dp[i]  = 1'bx;
        end
        dp_low_cnt = 0;
        fd_cnt     = 0;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_pend_val = 16'h0; m_act_val = 16'h0;
        m_pend_dp = 4'h0;   m_act_dp = 4'h0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    endtask

    // Advance one clock; predict pins from which digit/sub-step the elapsed time selects
    task automatic step();
        int d;
        int s;
        logic [3:0] nib;
        logic blank;
        @(posedge clock);
        if (!bus.enable) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
            m_cnt = 0;
        end else begin
            d     = (m_cnt / SLOT) % DIGITS;
            s     = (m_cnt % SLOT) / SUB_DIV;
            nib   = m_act_val[4*d +: 4];
            blank = bus.blank_lz && (d > 0) && ((m_act_val >> (4*d)) == 16'h0);
            if (s < int'(bus.brightness)) begin
                exp_an  = ~(4'b0001 << d);
                exp_seg = blank ? 7'h7F : ~dec_tab[nib];
                exp_dp  = ~m_act_dp[d];
            end else begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end
            exp_fd = ((m_cnt % FRAME) == FRAME - 1);
            if (exp_fd) begin
                m_act_val = bus.load ? bus.value : m_pend_val;
                m_act_dp  = bus.load ? bus.dp_in : m_pend_dp;
            end
            m_cnt++;
        end
        if (bus.load) begin
            m_pend_val = bus.value;
            m_pend_dp  = bus.dp_in;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.load = 1'b0; bus.value = 16'h0; bus.dp_in = 4'h0;
        bus.blank_lz = 1'b0; bus.brightness = 4'hF;
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.an !== 4'hF) begin fails++; $display("FAIL reset_an: got %b want 1111", bus.an); end
        checks++; if (bus.seg !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7f", bus.seg); end
        checks++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", bus.dp); end
        checks++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        model_reset();
        clear_tally();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL reset_idle: got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_basic();
        bus.enable = 1'b1; bus.brightness = 4'hF; bus.value = 16'h1234; bus.dp_in = 4'h0; bus.load = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            bus.load = 1'b0;
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL basic_frame0 t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        clear_tally();
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL basic_frame1 t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        for (int i = 0; i < DIGITS; i++) begin
            checks++; if (lit_cnt[i] != 30) begin fails++; $display("FAIL basic_lit%0d: got %0d want 30", i, lit_cnt[i]); end
        end
        checks++; if (last_seg[0] !== 7'h19) begin fails++; $display("FAIL basic_seg0: got %h want 19", last_seg[0]); end
        checks++; if (last_seg[1] !== 7'h30) begin fails++; $display("FAIL basic_seg1: got %h want 30", last_seg[1]); end
        checks++; if (last_seg[2] !== 7'h24) begin fails++; $display("FAIL basic_seg2: got %h want 24", last_seg[2]); end
        checks++; if (last_seg[3] !== 7'h79) begin fails++; $display("FAIL basic_seg3: got %h want 79", last_seg[3]); end
        checks++; if (fd_cnt != 1) begin fails++; $display("FAIL basic_fd_per_frame: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_midframe_load();
        for (int i = 0; i < FRAME / 2; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL mid_pre t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        clear_tally();
        bus.value = 16'hABCD; bus.load = 1'b1;
        for (int i = 0; i < FRAME / 2; i++) begin
            step();
            bus.load = 1'b0;
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL mid_rest t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        checks++; if (last_seg[3] !== 7'h79) begin fails++; $display("FAIL mid_old_seg3: got %h want 79", last_seg[3]); end
        checks++; if (lit_cnt[0] != 0) begin fails++; $display("FAIL mid_no_digit0: got %0d want 0", lit_cnt[0]); end
        clear_tally();
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL mid_new t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        checks++; if (last_seg[0] !== 7'h21) begin fails++; $display("FAIL mid_new_seg0: got %h want 21", last_seg[0]); end
        checks++; if (last_seg[3] !== 7'h08) begin fails++; $display("FAIL mid_new_seg3: got %h want 08", last_seg[3]); end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [2];
        logic [6:0]  want [2][4];
        vals[0] = 16'h0050; vals[1] = 16'h0000;
        want[0] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        want[1] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        bus.blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            bus.value = vals[v]; bus.load = 1'b1;
            for (int i = 0; i < 2 * FRAME; i++) begin
                if (i == FRAME) clear_tally();
                step();
                bus.load = 1'b0;
                checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL blank t=%0t: got %h want %h", $time, obs_v, exp_v); end
            end
            for (int d = 0; d < DIGITS; d++) begin
                checks++;
                if (last_seg[d] !== want[v][d]) begin
                    fails++; $display("FAIL blank_v%0d_seg%0d: got %h want %h", v, d, last_seg[d], want[v][d]);
                end
            end
        end
    endtask

    task automatic test_dp();
        bus.dp_in = 4'b0100; bus.value = 16'h0000; bus.load = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME) clear_tally();
            step();
            bus.load = 1'b0;
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL dp t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        checks++; if (dp_low_cnt != 30) begin fails++; $display("FAIL dp_lit_cycles: got %0d want 30", dp_low_cnt); end
        checks++; if (last_dp[2] !== 1'b0) begin fails++; $display("FAIL dp_digit2: got %b want 0", last_dp[2]); end
        checks++; if (last_dp[1] !== 1'b1) begin fails++; $display("FAIL dp_digit1: got %b want 1", last_dp[1]); end
        checks++; if (last_seg[2] !== 7'h7F) begin fails++; $display("FAIL dp_seg2_blank: got %h want 7f", last_seg[2]); end
    endtask

    task automatic test_brightness();
        int total;
        bus.brightness = 4'd4;
        clear_tally();
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL bright4 t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        for (int d = 0; d < DIGITS; d++) begin
            checks++; if (lit_cnt[d] != 8) begin fails++; $display("FAIL bright4_lit%0d: got %0d want 8", d, lit_cnt[d]); end
        end
        bus.brightness = 4'd0;
        clear_tally();
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL bright0 t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        total = lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3];
        checks++; if (total != 0) begin fails++; $display("FAIL bright0_dark: got %0d lit cycles want 0", total); end
        bus.brightness = 4'hF;
    endtask

    task automatic test_enable();
        for (int i = 0; i < 40; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL en_pre t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        bus.value = 16'h5678; bus.dp_in = 4'h0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL en_load: got %h want %h", obs_v, exp_v); end
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL en_off t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        bus.enable = 1'b1;
        step();
        checks++; if (bus.an !== 4'b1110) begin fails++; $display("FAIL en_restart_digit0: got %b want 1110", bus.an); end
        for (int i = 1; i < FRAME; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL en_frame0 t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        clear_tally();
        for (int i = 0; i < FRAME; i++) begin
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL en_frame1 t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        checks++; if (last_seg[0] !== 7'h00) begin fails++; $display("FAIL en_pending_seg0: got %h want 00", last_seg[0]); end
        checks++; if (last_seg[3] !== 7'h12) begin fails++; $display("FAIL en_pending_seg3: got %h want 12", last_seg[3]); end
    endtask

    task automatic test_reset_midframe();
        bus.blank_lz = 1'b0; bus.value = 16'h9999; bus.load = 1'b1;
        for (int i = 0; i < 37; i++) begin
            step();
            bus.load = 1'b0;
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL rst_mid_pre t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.an !== 4'hF) begin fails++; $display("FAIL rst_mid_an: got %b want 1111", bus.an); end
        checks++; if (bus.seg !== 7'h7F) begin fails++; $display("FAIL rst_mid_seg: got %h want 7f", bus.seg); end
        checks++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL rst_mid_dp: got %b want 1", bus.dp); end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME) clear_tally();
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL rst_mid_post t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        checks++; if (last_seg[0] !== 7'h40) begin fails++; $display("FAIL rst_mid_lost_seg0: got %h want 40", last_seg[0]); end
        checks++; if (last_seg[3] !== 7'h40) begin fails++; $display("FAIL rst_mid_lost_seg3: got %h want 40", last_seg[3]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.load = ($urandom_range(0, 19) == 0);
            if (bus.load) begin
                bus.value = 16'($urandom());
                if ($urandom_range(0, 2) == 0) bus.value = bus.value & 16'h00FF;
                bus.dp_in = 4'($urandom());
            end
            if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 49) == 0) bus.brightness = 4'($urandom());
            if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
            step();
            checks++; if (obs_v !== exp_v) begin fails++; $display("FAIL random t=%0t: got %h want %h", $time, obs_v, exp_v); end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe_load();
        test_blanking();
        test_dp();
        test_brightness();
        test_enable();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
